// File: rtl/handshake_rx_fifo.sv
// handshake_rx_fifo: valid/ready receiver with FWFT buffer and sticky master protocol checker
module handshake_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in_s,
  output logic              ready,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  level,
  output logic              proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] data_q;
  logic stall_q, push, pop;
  // ready comes only from registered state and busy/rst, so out_ready never reaches it
  always_comb begin
    ready = !rst && !busy && (level != FULL);
    out_valid = level != '0;
    push = valid && ready;
    pop = out_valid && out_ready;
    data_out_s = out_valid ? mem[rd_ptr] : '0;
  end
  // storage is left unreset; push is already blocked during rst
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in_s;
  // pointers, occupancy and protocol checker
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      stall_q <= 1'b0;
      data_q <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= (push && !pop) ? level + CNT_W'(1) : (pop && !push) ? level - CNT_W'(1) : level;
      stall_q <= valid && !ready;
      data_q <= data_in_s;
      proto_err <= proto_err || (stall_q && (!valid || data_in_s != data_q));
    end
endmodule

// File: tb/tb_handshake_rx_fifo.sv
// tb_handshake_rx_fifo: directed scenarios plus random traffic against a queue-based model
module tb_handshake_rx_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, valid, busy, out_ready, ready, out_valid, proto_err;
  logic [7:0] data_in_s, data_out_s;
  logic [2:0] level;
  int n_tests = 0, n_fail = 0;
  bit checking = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit m_err, m_stall, m_ready;
  logic [7:0] m_dprev;

  handshake_rx_fifo dut (
    .clk(clk), .rst(rst), .valid(valid), .data_in_s(data_in_s), .ready(ready),
    .busy(busy), .data_out_s(data_out_s), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic b, input logic o);
    rst = r; valid = v; data_in_s = d; busy = b; out_ready = o;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      m_stall = 1'b0;
    end else begin
      m_ready = !busy && mq.size() != DEPTH;
      if (m_stall && (!valid || data_in_s != m_dprev)) m_err = 1'b1;
      m_stall = valid && !m_ready;
      m_dprev = data_in_s;
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (valid && m_ready) mq.push_back(data_in_s);
    end
  end

  always @(negedge clk) if (checking) begin
    chk("ready", ready, !rst && !busy && mq.size() != DEPTH);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("data_out_s", data_out_s, mq.size() != 0 ? mq[0] : 8'h00);
    chk("level", level, mq.size());
    chk("proto_err", proto_err, m_err);
    if (out_valid && out_ready && !rst) got.push_back(data_out_s);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data_in_s = '0; busy = 1'b0; out_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    checking = 1'b1;
    chk("rst_ready", ready, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out_s, 0);
    chk("rst_proto", proto_err, 0);
    step(1, 0, 0, 0, 0);
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 8'(i), 0, 1);
      chk("stream_level_le1", level <= 1, 1);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_order", got[i], i + 1);
    chk("stream_proto", proto_err, 0);
    got.delete();
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    chk("fill_level", level, 4);
    chk("fill_ready", ready, 0);
    step(0, 1, 8'h14, 0, 0);
    step(0, 1, 8'h14, 0, 0);
    chk("fill_held_level", level, 4);
    step(0, 1, 8'h14, 0, 1);
    chk("fill_ready_back", ready, 1);
    step(0, 1, 8'h14, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("fill_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("fill_order", got[i], 8'h10 + i);
    chk("fill_proto", proto_err, 0);
    got.delete();
    step(0, 1, 8'h20, 0, 0);
    step(0, 1, 8'h21, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'h22 + 8'(i), 0, 1);
      chk("wrap_level", level, 2);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("wrap_count", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++) chk("wrap_order", got[i], 8'h20 + i);
    chk("wrap_proto", proto_err, 0);
    got.delete();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h55, 1, 1);
      chk("busy_ready", ready, 0);
    end
    step(0, 1, 8'h55, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("busy_count", got.size(), 1);
    if (got.size() > 0) chk("busy_word", got[0], 8'h55);
    chk("busy_proto", proto_err, 0);
    step(0, 1, 8'h55, 1, 0);
    step(0, 1, 8'h56, 1, 0);
    chk("viol_data", proto_err, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("viol_sticky", proto_err, 1);
    step(1, 0, 0, 0, 0);
    chk("viol_rst_clear", proto_err, 0);
    step(0, 1, 8'h77, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("viol_drop", proto_err, 1);
    step(1, 0, 0, 0, 0);
    chk("viol_drop_clear", proto_err, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h31 + 8'(i), 0, 0);
    chk("mid_level3", level, 3);
    step(1, 0, 0, 0, 0);
    chk("mid_level", level, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_data", data_out_s, 0);
    got.delete();
    step(0, 1, 8'hA0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mid_count", got.size(), 1);
    if (got.size() > 0) chk("mid_word", got[0], 8'hA0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, 1'($urandom), 8'($urandom), $urandom_range(3) == 0, 1'($urandom));
    step(0, 0, 0, 0, 1);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
